fir_sample_tx: RTL and testbench



---
 rtl/fir_stream_pkg.sv | 9 +
 rtl/sample_fifo.sv | 67 ++++++
 rtl/fir_sample_tx.sv | 107 ++++++++++
 tb/tb_fir_sample_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// Shared sample types for the 16-bit FIR stream path.
// Used by the transmit feeder and the filter datapath.
package fir_stream_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with extra-MSB pointers.
// Async active-low reset discards contents by clearing pointers.
module sample_fifo
    import fir_stream_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic signed [SAMPLE_W-1:0] din,
    output logic signed [SAMPLE_W-1:0] dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    sample_t     mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fir_sample_tx.sv
// Transmit feeder: buffers producer samples and plays them out
// at a programmable pace, zero-stuffing on underflow.
module fir_sample_tx
    import fir_stream_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [DIV_W-1:0]           rate_div,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       out_stb,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       underflow,
    input  logic                       underflow_clr
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] div_last;
    logic             tick;

    sample_t out_data_q;
    sample_t out_data_d;
    logic    out_stb_q;
    logic    out_stb_d;
    logic    underflow_q;
    logic    underflow_d;

    sample_t fifo_dout;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = tick && !fifo_empty;

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A shrinking divider that leaves cnt past the new end ticks at once.
    assign div_eff  = (rate_div == '0) ? DIV_W'(1) : rate_div;
    assign div_last = div_eff - DIV_W'(1);
    assign tick     = en && (cnt_q >= div_last);

    always_comb begin
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_stb_d   = 1'b0;
        underflow_d = underflow_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (underflow_clr) begin
            underflow_d = 1'b0;
        end
        if (tick) begin
            out_stb_d = 1'b1;
            if (fifo_empty) begin
                out_data_d  = '0;
                underflow_d = 1'b1;
            end else begin
                out_data_d = fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_stb_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_stb_q   <= out_stb_d;
            underflow_q <= underflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_stb   = out_stb_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed bench for fir_sample_tx: vector table plus
// hand-written pacing, backpressure and reset sequences.
module tb_fir_sample_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] rate_div;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_stb;
    logic [3:0]  fifo_level;
    logic        underflow;
    logic        underflow_clr;

    int total = 0;
    int bad   = 0;

    fir_sample_tx #(
        .DEPTH (8),
        .DIV_W (16)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .en            (en),
        .rate_div      (rate_div),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_stb       (out_stb),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] rate;
        logic        vld;
        logic [15:0] din;
        logic        clr;
        logic [15:0] e_data;
        logic        e_stb;
        logic        e_uf;
        logic [3:0]  e_lvl;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en            = 1'b0;
        in_valid      = 1'b0;
        underflow_clr = 1'b0;
    endtask

    logic [15:0] smp [6];
    logic [15:0] model [$];
    logic [15:0] expv;
    int          acc_cnt;
    int          extra;
    int          nstb;
    logic        acc;

    initial begin
        tbl[0]  = '{1'b0, 16'd1, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b1};
        tbl[1]  = '{1'b0, 16'd1, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd2, 1'b1};
        tbl[2]  = '{1'b0, 16'd1, 1'b1, 16'hFF00, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 1'b1};
        tbl[3]  = '{1'b1, 16'd1, 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b1, 1'b0, 4'd2, 1'b1};
        tbl[4]  = '{1'b1, 16'd1, 1'b0, 16'h0000, 1'b0, 16'h0200, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[5]  = '{1'b1, 16'd1, 1'b0, 16'h0000, 1'b0, 16'hFF00, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[6]  = '{1'b1, 16'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1};
        tbl[7]  = '{1'b1, 16'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1};
        tbl[8]  = '{1'b0, 16'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b1};
        tbl[9]  = '{1'b0, 16'd1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b1};
        tbl[10] = '{1'b0, 16'd0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b1};
        tbl[11] = '{1'b1, 16'd0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[12] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 4'd0, 1'b1};

        rst_n    = 1'b0;
        rate_div = 16'd1;
        in_data  = '0;
        idle();
        #12;
        chk("rst_data", out_data, 16'h0000);
        chk("rst_stb", out_stb, 1'b0);
        chk("rst_uf", underflow, 1'b0);
        chk("rst_lvl", fifo_level, 4'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rdy_after_rst", in_ready, 1'b1);

        // basic stream and rate_div = 0 via the vector table
        for (int i = 0; i < 13; i++) begin
            en            = tbl[i].en;
            rate_div      = tbl[i].rate;
            in_valid      = tbl[i].vld;
            in_data       = tbl[i].din;
            underflow_clr = tbl[i].clr;
            step();
            chk($sformatf("v%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("v%0d_stb", i), out_stb, tbl[i].e_stb);
            chk($sformatf("v%0d_uf", i), underflow, tbl[i].e_uf);
            chk($sformatf("v%0d_lvl", i), fifo_level, tbl[i].e_lvl);
            chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].e_rdy);
        end
        idle();

        // pacing at rate 4 with a preloaded FIFO
        smp[0] = 16'h1001; smp[1] = 16'h8002; smp[2] = 16'h7FFF;
        smp[3] = 16'h0004; smp[4] = 16'hFFFF; smp[5] = 16'h0A0A;
        rate_div = 16'd4;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = smp[i];
            step();
            chk("pre_nostb", out_stb, 1'b0);
        end
        in_valid = 1'b0;
        step();
        chk("pre_nostb_idle", out_stb, 1'b0);
        chk("pre_lvl", fifo_level, 4'd6);
        en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("pace_stb%0d", k), out_stb, (k % 4) == 0);
            if ((k % 4) == 0) begin
                chk($sformatf("pace_data%0d", k), out_data, smp[k/4-1]);
            end
        end
        chk("pace_uf", underflow, 1'b0);
        chk("pace_lvl", fifo_level, 4'd0);
        idle();

        // fill to full with in_valid held, then drain with 2 late accepts
        acc_cnt = 0;
        model.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h2000 + 16'(acc_cnt);
            acc      = in_ready;
            step();
            if (acc) begin
                model.push_back(in_data);
                acc_cnt++;
            end
        end
        chk("full_accepts", acc_cnt, 8);
        chk("full_lvl", fifo_level, 4'd8);
        chk("full_rdy", in_ready, 1'b0);
        en       = 1'b1;
        rate_div = 16'd1;
        extra    = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (extra < 2);
            in_data  = 16'h2000 + 16'(acc_cnt);
            acc      = in_valid && in_ready;
            expv     = (model.size() == 0) ? 16'h0000 : model[0];
            step();
            chk($sformatf("drain_stb%0d", i), out_stb, 1'b1);
            chk($sformatf("drain_data%0d", i), out_data, expv);
            if (model.size() != 0) begin
                void'(model.pop_front());
            end
            if (acc) begin
                model.push_back(in_data);
                acc_cnt++;
                extra++;
            end
        end
        chk("drain_extra", extra, 2);
        chk("drain_lvl", fifo_level, 4'd0);
        chk("drain_uf", underflow, 1'b0);
        idle();

        // push on an empty tick
        in_valid = 1'b1;
        in_data  = 16'h4321;
        en       = 1'b1;
        step();
        chk("epush_data", out_data, 16'h0000);
        chk("epush_stb", out_stb, 1'b1);
        chk("epush_uf", underflow, 1'b1);
        chk("epush_lvl", fifo_level, 4'd1);
        in_valid = 1'b0;
        step();
        chk("epush_next", out_data, 16'h4321);
        chk("epush_lvl0", fifo_level, 4'd0);
        en            = 1'b0;
        underflow_clr = 1'b1;
        step();
        chk("uf_cleared", underflow, 1'b0);
        idle();

        // push and pop together at level 3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h5000 + 16'(i);
            step();
        end
        chk("pp_lvl_pre", fifo_level, 4'd3);
        in_data = 16'h5003;
        en      = 1'b1;
        step();
        chk("pp_lvl", fifo_level, 4'd3);
        chk("pp_data", out_data, 16'h5000);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("pp_drain%0d", i), out_data, 16'h5000 + 16'(i));
        end
        chk("pp_uf", underflow, 1'b0);
        idle();

        // clear racing an empty tick, then clear on a non-empty tick
        en            = 1'b1;
        underflow_clr = 1'b1;
        step();
        chk("race_uf", underflow, 1'b1);
        idle();
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        step();
        in_valid      = 1'b0;
        en            = 1'b1;
        underflow_clr = 1'b1;
        step();
        chk("clr_uf", underflow, 1'b0);
        chk("clr_data", out_data, 16'hBEEF);
        idle();

        // asynchronous reset with 5 samples buffered
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h6000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        rate_div = 16'd2;
        en       = 1'b1;
        step();
        chk("mr_lvl_pre", fifo_level, 4'd5);
        rst_n = 1'b0;
        #1;
        chk("mr_data", out_data, 16'h0000);
        chk("mr_stb", out_stb, 1'b0);
        chk("mr_uf", underflow, 1'b0);
        chk("mr_lvl", fifo_level, 4'd0);
        step();
        rst_n = 1'b1;
        nstb  = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_stb) begin
                nstb++;
                chk($sformatf("mr_zero%0d", i), out_data, 16'h0000);
            end
        end
        chk("mr_nstb", nstb, 4);
        chk("mr_uf_after", underflow, 1'b1);
        chk("mr_lvl_after", fifo_level, 4'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
